// File: rtl/mux_32_pkg.sv
// Shared constants for the 32:1 selector and its 16:1 halves.
package mux_32_pkg;

    localparam int MUX32_SEL_W  = 5;
    localparam int MUX32_NUM_IN = 32;

    localparam int MUX16_SEL_W  = MUX32_SEL_W - 1;
    localparam int MUX16_NUM_IN = MUX32_NUM_IN / 2;

endpackage

// File: rtl/mux_32_mux_16.sv
// Purely combinational 16:1 selector, N bits wide; one half of mux_32.
module mux_16
    import mux_32_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [MUX16_SEL_W-1:0] select,
    input  logic [N-1:0]           in00,
    input  logic [N-1:0]           in01,
    input  logic [N-1:0]           in02,
    input  logic [N-1:0]           in03,
    input  logic [N-1:0]           in04,
    input  logic [N-1:0]           in05,
    input  logic [N-1:0]           in06,
    input  logic [N-1:0]           in07,
    input  logic [N-1:0]           in08,
    input  logic [N-1:0]           in09,
    input  logic [N-1:0]           in10,
    input  logic [N-1:0]           in11,
    input  logic [N-1:0]           in12,
    input  logic [N-1:0]           in13,
    input  logic [N-1:0]           in14,
    input  logic [N-1:0]           in15,
    output logic [N-1:0]           out
);

    logic [N-1:0] in_arr [MUX16_NUM_IN];

    assign in_arr[0]  = in00;
    assign in_arr[1]  = in01;
    assign in_arr[2]  = in02;
    assign in_arr[3]  = in03;
    assign in_arr[4]  = in04;
    assign in_arr[5]  = in05;
    assign in_arr[6]  = in06;
    assign in_arr[7]  = in07;
    assign in_arr[8]  = in08;
    assign in_arr[9]  = in09;
    assign in_arr[10] = in10;
    assign in_arr[11] = in11;
    assign in_arr[12] = in12;
    assign in_arr[13] = in13;
    assign in_arr[14] = in14;
    assign in_arr[15] = in15;

    // Every code is a valid index, so only the addressed entry reaches out.
    assign out = in_arr[select];

endmodule

// File: rtl/mux_32.sv
// 32:1 N-bit selector: combinational out plus a one-cycle registered copy out_q.
module mux_32
    import mux_32_pkg::*;
#(
    parameter int N = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MUX32_SEL_W-1:0] select,
    input  logic [N-1:0]           in00,
    input  logic [N-1:0]           in01,
    input  logic [N-1:0]           in02,
    input  logic [N-1:0]           in03,
    input  logic [N-1:0]           in04,
    input  logic [N-1:0]           in05,
    input  logic [N-1:0]           in06,
    input  logic [N-1:0]           in07,
    input  logic [N-1:0]           in08,
    input  logic [N-1:0]           in09,
    input  logic [N-1:0]           in10,
    input  logic [N-1:0]           in11,
    input  logic [N-1:0]           in12,
    input  logic [N-1:0]           in13,
    input  logic [N-1:0]           in14,
    input  logic [N-1:0]           in15,
    input  logic [N-1:0]           in16,
    input  logic [N-1:0]           in17,
    input  logic [N-1:0]           in18,
    input  logic [N-1:0]           in19,
    input  logic [N-1:0]           in20,
    input  logic [N-1:0]           in21,
    input  logic [N-1:0]           in22,
    input  logic [N-1:0]           in23,
    input  logic [N-1:0]           in24,
    input  logic [N-1:0]           in25,
    input  logic [N-1:0]           in26,
    input  logic [N-1:0]           in27,
    input  logic [N-1:0]           in28,
    input  logic [N-1:0]           in29,
    input  logic [N-1:0]           in30,
    input  logic [N-1:0]           in31,
    output logic [N-1:0]           out,
    output logic [N-1:0]           out_q
);

    logic [N-1:0] lo_out;
    logic [N-1:0] hi_out;
    logic [N-1:0] out_p1;

    mux_16 #(.N(N)) u_lo (
        .select (select[MUX16_SEL_W-1:0]),
        .in00 (in00), .in01 (in01), .in02 (in02), .in03 (in03),
        .in04 (in04), .in05 (in05), .in06 (in06), .in07 (in07),
        .in08 (in08), .in09 (in09), .in10 (in10), .in11 (in11),
        .in12 (in12), .in13 (in13), .in14 (in14), .in15 (in15),
        .out    (lo_out)
    );

    mux_16 #(.N(N)) u_hi (
        .select (select[MUX16_SEL_W-1:0]),
        .in00 (in16), .in01 (in17), .in02 (in18), .in03 (in19),
        .in04 (in20), .in05 (in21), .in06 (in22), .in07 (in23),
        .in08 (in24), .in09 (in25), .in10 (in26), .in11 (in27),
        .in12 (in28), .in13 (in29), .in14 (in30), .in15 (in31),
        .out    (hi_out)
    );

    assign out = select[MUX32_SEL_W-1] ? hi_out : lo_out;

    // Stage p0 -> p1: registered copy of the selected data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1 <= '0;
        end else begin
            out_p1 <= out;
        end
    end

    assign out_q = out_p1;

endmodule

// File: tb/tb_mux_32.sv
// Directed bench for mux_32 at N=1 and N=8 sharing clock, reset and select.
module tb_mux_32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  select;
    logic [31:0] in1;
    logic [7:0]  in8 [32];
    logic        out1, outq1;
    logic [7:0]  out8, outq8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_32 #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .select(select),
        .in00(in1[0]),  .in01(in1[1]),  .in02(in1[2]),  .in03(in1[3]),
        .in04(in1[4]),  .in05(in1[5]),  .in06(in1[6]),  .in07(in1[7]),
        .in08(in1[8]),  .in09(in1[9]),  .in10(in1[10]), .in11(in1[11]),
        .in12(in1[12]), .in13(in1[13]), .in14(in1[14]), .in15(in1[15]),
        .in16(in1[16]), .in17(in1[17]), .in18(in1[18]), .in19(in1[19]),
        .in20(in1[20]), .in21(in1[21]), .in22(in1[22]), .in23(in1[23]),
        .in24(in1[24]), .in25(in1[25]), .in26(in1[26]), .in27(in1[27]),
        .in28(in1[28]), .in29(in1[29]), .in30(in1[30]), .in31(in1[31]),
        .out(out1), .out_q(outq1)
    );

    mux_32 #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .select(select),
        .in00(in8[0]),  .in01(in8[1]),  .in02(in8[2]),  .in03(in8[3]),
        .in04(in8[4]),  .in05(in8[5]),  .in06(in8[6]),  .in07(in8[7]),
        .in08(in8[8]),  .in09(in8[9]),  .in10(in8[10]), .in11(in8[11]),
        .in12(in8[12]), .in13(in8[13]), .in14(in8[14]), .in15(in8[15]),
        .in16(in8[16]), .in17(in8[17]), .in18(in8[18]), .in19(in8[19]),
        .in20(in8[20]), .in21(in8[21]), .in22(in8[22]), .in23(in8[23]),
        .in24(in8[24]), .in25(in8[25]), .in26(in8[26]), .in27(in8[27]),
        .in28(in8[28]), .in29(in8[29]), .in30(in8[30]), .in31(in8[31]),
        .out(out8), .out_q(outq8)
    );

    typedef struct {
        logic [4:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t bnd_tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pat;
        pat = 32'hA5C3_96E1;

        rst    = 1'b0;
        select = 5'd0;
        in1    = '0;
        for (int k = 0; k < 32; k++) in8[k] = 8'h00;

        // Exhaustive walk, N=1: in k carries bit k of the pattern.
        in1 = pat;
        for (int s = 0; s < 32; s++) begin
            select = 5'(s);
            #1;
            chk($sformatf("walk sel=%0d", s), {31'd0, out1}, {31'd0, pat[s]});
        end

        // One-hot isolation on in17.
        in1 = 32'h0002_0000;
        for (int s = 0; s < 32; s++) begin
            select = 5'(s);
            #1;
            chk($sformatf("onehot17 sel=%0d", s), {31'd0, out1}, (s == 17) ? 32'd1 : 32'd0);
        end

        // Unselected-input immunity at select=5.
        select = 5'd5;
        in1    = 32'h0000_0020;
        #1;
        chk("immune base", {31'd0, out1}, 32'd1);
        in1 = 32'hFFFF_FFFF;
        #1;
        chk("immune all-ones", {31'd0, out1}, 32'd1);
        in1 = 32'h0000_0020;
        #1;
        chk("immune toggled back", {31'd0, out1}, 32'd1);
        for (int k = 0; k < 32; k++) if (k != 5) in1[k] = 1'bx;
        #1;
        chk("immune x others", {31'd0, out1}, 32'd1);

        // Boundary codes, N=8.
        in8[0]  = 8'h3C;
        in8[15] = 8'h7E;
        in8[16] = 8'h81;
        in8[31] = 8'hFF;
        bnd_tbl[0] = '{sel: 5'd0,  exp: 8'h3C};
        bnd_tbl[1] = '{sel: 5'd15, exp: 8'h7E};
        bnd_tbl[2] = '{sel: 5'd16, exp: 8'h81};
        bnd_tbl[3] = '{sel: 5'd31, exp: 8'hFF};
        for (int i = 0; i < 4; i++) begin
            select = bnd_tbl[i].sel;
            #1;
            chk($sformatf("boundary sel=%0d", bnd_tbl[i].sel), {24'd0, out8}, {24'd0, bnd_tbl[i].exp});
        end

        // Register and reset sequence, N=8.
        @(negedge clk);
        select = 5'd31;
        rst    = 1'b1;
        edge_sample();
        chk("rst edge1 out_q", {24'd0, outq8}, 32'd0);
        chk("rst edge1 out", {24'd0, out8}, 32'hFF);
        edge_sample();
        chk("rst edge2 out_q", {24'd0, outq8}, 32'd0);
        chk("rst edge2 out", {24'd0, out8}, 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        chk("release out_q", {24'd0, outq8}, 32'hFF);
        @(negedge clk);
        select = 5'd16;
        #1;
        chk("sel16 out before edge", {24'd0, out8}, 32'h81);
        chk("sel16 out_q holds", {24'd0, outq8}, 32'hFF);
        edge_sample();
        chk("sel16 out_q", {24'd0, outq8}, 32'h81);
        @(negedge clk);
        rst = 1'b1;
        edge_sample();
        chk("mid rst out_q", {24'd0, outq8}, 32'd0);
        chk("mid rst out", {24'd0, out8}, 32'h81);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        chk("reload out_q", {24'd0, outq8}, 32'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_32.md
Name: mux_32

Overview:
- 32:1 selector that routes one of 32 independent data inputs, in00..in31, to a single output under a 5-bit select.
- Primary output `out` is purely combinational. A registered copy `out_q` is provided for timing-critical consumers.
- General-purpose datapath leaf, e.g. a register-file read port or a bit-select stage.

Parameters:
- N, default 1, width in bits of each data input and of both outputs.

Ports:
- clk  input  1  system clock; used only by the `out_q` register.
- rst  input  1  synchronous, active-high reset; acts on the `out_q` register only.
- select  input  5  index of the input to route; 0 selects in00, 31 selects in31.
- in00 .. in31  input  N each  32 data inputs, one port per index, numbered with two decimal digits.
- out  output  N  combinational selected data.
- out_q  output  N  registered selected data.

Behaviour:
- The design has one clock and a synchronous active-high reset. Clock port: clk. Reset port: rst.
- Combinational path:
  - out = in[select], where in[k] is the port inK with two-digit k.
  - Zero cycles of latency, with no state on this path.
  - out responds to changes on select or on the selected input within the same delta/settle time.
  - Changes on unselected inputs must not affect out.
- All 32 select codes are legal. There is no out-of-range case and no default-to-X path.
- X/Z handling: out reflects only the selected input. An X on any unselected input must not propagate to out.
- Registered path:
  - On each rising edge of clk: if rst = 1, out_q <= 0; otherwise out_q <= out.
  - Latency is 1 cycle.
- Reset:
  - out_q reset value is all zeros.
  - out is not affected by rst and stays combinationally valid during reset.
  - If rst is asserted mid-operation, out_q is cleared at the next edge. It reloads the current selection on the first edge after rst is released.
- Simultaneous change of select and the data inputs: out settles to the new in[select]. out_q captures whatever value out has at the edge.
- Width: all data is exactly N bits. No extension or truncation happens inside the block; a wider sink zero-extends outside.
- No handshake. The block is always ready and always valid.

Decomposition:
- Shared package holds:
  - localparam MUX32_SEL_W = 5
  - localparam MUX32_NUM_IN = 32
- Natural sub-module: mux_16 (16:1, N-bit, combinational).
  - mux_32 = two mux_16 instances, lower (in00..in15) and upper (in16..in31), selected by select[3:0].
  - select[4] then picks between the two mux_16 outputs.
  - mux_16 may itself recurse down to a mux_2 leaf.
- The out_q register lives in mux_32 only.

Test Plan:
- Exhaustive walk, N=1, data pattern 0xA5C3_96E1 (in k = bit k):
  - Step select through 0..31 with 1 ns settle per step.
  - Required: out == bit select of the pattern at every step, e.g. select=0 gives out=1 and select=1 gives out=0.
- One-hot isolation:
  - Drive only in17=1, all others 0, and sweep select.
  - Required: out=1 only at select=17 (5'b10001), out=0 for the other 31 codes.
- Unselected-input immunity:
  - Hold select=5 with in05=1, toggle all other inputs and set them to X.
  - Required: out stays 1 with no glitch to X.
- Boundary codes, N=8:
  - in00=8'h3C, in15=8'h7E, in16=8'h81, in31=8'hFF.
  - Required: select 0, 15, 16, 31 give out 8'h3C, 8'h7E, 8'h81, 8'hFF respectively.
- Register and reset, N=8, select=31, in31=8'hFF:
  - With rst=1 for 2 edges: out_q=0 while out=8'hFF.
  - Drop rst: out_q=8'hFF after 1 edge.
  - Change select to 16: out_q=8'h81 one edge later.
  - Reassert rst mid-run: out_q=0 at the next edge.
